// File: rtl/edge_timestamp_monitor.sv
// edge_timestamp_monitor
//   Watches a serial bit that is already synchronous to clk and reports
//   every transition on it. For each edge it:
//     - raises rise_pulse or fall_pulse for one cycle;
//     - bumps a saturating edge counter;
//     - latches how long the previous level was held (run_len);
//     - offers a {polarity, timestamp} record on a valid/ready port.
//   If a record is still waiting when the next edge arrives, the new record
//   is dropped and ovf is set (sticky until clr_cnt).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   din               monitored serial bit
//   en                monitor enable (record handshake keeps running when low)
//   clr_cnt           clears edge_cnt and ovf
//   rise_pulse        one-cycle pulse after a 0->1 edge
//   fall_pulse        one-cycle pulse after a 1->0 edge
//   edge_cnt          saturating count of detected edges
//   run_len           length of the last completed stable run, saturating
//   rec_valid/ready   record handshake
//   rec_data          {polarity (1=rise), timestamp at detection}
//   ovf               sticky "record dropped" flag
module edge_timestamp_monitor #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr_cnt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [TS_W:0]    rec_data,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

    logic             d1_q,       d1_d;
    logic             primed_q,   primed_d;
    logic [TS_W-1:0]  ts_q,       ts_d;
    logic [CNT_W-1:0] run_cnt_q,  run_cnt_d;
    logic [CNT_W-1:0] run_len_q,  run_len_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             rise_q,     rise_d;
    logic             fall_q,     fall_d;
    logic             rec_valid_q, rec_valid_d;
    logic [TS_W:0]    rec_data_q, rec_data_d;
    logic             ovf_q,      ovf_d;

    logic edge_det;
    logic xfer;
    logic rec_load;
    logic rec_drop;

    always_comb begin
        // The first enabled cycle after reset only loads d1 (primed_q=0),
        // so a din that powers up high is not mistaken for a rising edge.
        edge_det = en && primed_q && (din != d1_q);
        xfer     = rec_valid_q && rec_ready;
        // A slot is free if empty or being emptied at this same edge.
        rec_load = edge_det && (!rec_valid_q || rec_ready);
        rec_drop = edge_det && rec_valid_q && !rec_ready;

        d1_d        = d1_q;
        primed_d    = primed_q;
        ts_d        = ts_q;
        run_cnt_d   = run_cnt_q;
        run_len_d   = run_len_q;
        edge_cnt_d  = edge_cnt_q;
        rec_valid_d = rec_valid_q;
        rec_data_d  = rec_data_q;

        rise_d = edge_det && din;
        fall_d = edge_det && !din;

        if (en) begin
            d1_d     = din;
            primed_d = 1'b1;
            ts_d     = ts_q + TS_ONE;
            if (edge_det) begin
                run_len_d = run_cnt_q;
                run_cnt_d = CNT_ONE;   // the edge cycle starts the new run
            end else if (run_cnt_q != CNT_MAX) begin
                run_cnt_d = run_cnt_q + CNT_ONE;
            end
        end

        // Clear wins over the old value, but an edge at the same posedge
        // still counts.
        if (clr_cnt) begin
            edge_cnt_d = edge_det ? CNT_ONE : '0;
        end else if (edge_det && (edge_cnt_q != CNT_MAX)) begin
            edge_cnt_d = edge_cnt_q + CNT_ONE;
        end

        ovf_d = (clr_cnt ? 1'b0 : ovf_q) | rec_drop;

        if (rec_load) begin
            rec_valid_d = 1'b1;
            rec_data_d  = {din, ts_q};
        end else if (xfer) begin
            rec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_q        <= 1'b0;
            primed_q    <= 1'b0;
            ts_q        <= '0;
            run_cnt_q   <= '0;
            run_len_q   <= '0;
            edge_cnt_q  <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            d1_q        <= d1_d;
            primed_q    <= primed_d;
            ts_q        <= ts_d;
            run_cnt_q   <= run_cnt_d;
            run_len_q   <= run_len_d;
            edge_cnt_q  <= edge_cnt_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_cnt   = edge_cnt_q;
    assign run_len    = run_len_q;
    assign rec_valid  = rec_valid_q;
    assign rec_data   = rec_data_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_edge_timestamp_monitor.sv
module tb_edge_timestamp_monitor;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        rst_n, din, en, clr_cnt, rec_ready;
    logic        rise_pulse, fall_pulse, rec_valid, ovf;
    logic [15:0] edge_cnt, run_len;
    logic [32:0] rec_data;

    edge_timestamp_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_cnt(clr_cnt),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_cnt(edge_cnt), .run_len(run_len),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .ovf(ovf)
    );

    // narrow instance for wrap / saturation
    logic       b_rst_n, b_din, b_en, b_clr_cnt, b_rec_ready;
    logic       b_rise, b_fall, b_rec_valid, b_ovf;
    logic [3:0] b_edge_cnt, b_run_len;
    logic [4:0] b_rec_data;

    edge_timestamp_monitor #(.TS_W(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(b_rst_n), .din(b_din), .en(b_en), .clr_cnt(b_clr_cnt),
        .rise_pulse(b_rise), .fall_pulse(b_fall),
        .edge_cnt(b_edge_cnt), .run_len(b_run_len),
        .rec_valid(b_rec_valid), .rec_ready(b_rec_ready),
        .rec_data(b_rec_data), .ovf(b_ovf)
    );

    int passes = 0;
    int total  = 0;
    logic [31:0] ts_m;       // enabled posedges since reset
    logic [32:0] sb[$];      // expected records, in order

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // advance one posedge, keep the timestamp model in step, settle
    task automatic tick();
        @(posedge clk);
        if (!rst_n) ts_m = '0;
        else if (en) ts_m = ts_m + 32'd1;
        #1;
    endtask

    task automatic push_edge(input logic new_din);
        din = new_din;
        sb.push_back({new_din, ts_m});
    endtask

    // A transfer happens at the next posedge if valid&ready and not in reset.
    always @(negedge clk) begin
        if (rst_n && rec_valid && rec_ready) begin
            check("xfer_pending", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) check("xfer_data", 64'(rec_data), 64'(sb.pop_front()));
        end
    end

    initial begin
        ts_m = '0;
        rst_n = 1'b0; din = 1'b0; en = 1'b0; clr_cnt = 1'b0; rec_ready = 1'b0;
        b_rst_n = 1'b0; b_din = 1'b0; b_en = 1'b0; b_clr_cnt = 1'b0; b_rec_ready = 1'b0;
        tick(); tick();

        // reset state
        check("rst_rise",  64'(rise_pulse), 64'd0);
        check("rst_fall",  64'(fall_pulse), 64'd0);
        check("rst_ecnt",  64'(edge_cnt),   64'd0);
        check("rst_runl",  64'(run_len),    64'd0);
        check("rst_valid", 64'(rec_valid),  64'd0);
        check("rst_data",  64'(rec_data),   64'd0);
        check("rst_ovf",   64'(ovf),        64'd0);

        // priming: din high from the first enabled cycle is not an edge
        rst_n = 1'b1; en = 1'b1; din = 1'b1; rec_ready = 1'b1;
        tick();
        check("prime_rise", 64'(rise_pulse), 64'd0);
        tick();
        check("prime_rise2", 64'(rise_pulse), 64'd0);
        check("prime_ecnt",  64'(edge_cnt),   64'd0);
        check("prime_valid", 64'(rec_valid),  64'd0);

        // four low cycles then a rise
        rst_n = 1'b0; tick();
        rst_n = 1'b1; din = 1'b0;
        repeat (4) tick();
        push_edge(1'b1);
        tick();
        check("rise_pulse", 64'(rise_pulse), 64'd1);
        check("rise_nofall", 64'(fall_pulse), 64'd0);
        check("rise_runl",  64'(run_len),    64'd4);
        check("rise_ecnt",  64'(edge_cnt),   64'd1);
        check("rise_valid", 64'(rec_valid),  64'd1);
        check("rise_data",  64'(rec_data),   {31'd0, 1'b1, 32'd4});
        tick();
        check("rise_pulse_end", 64'(rise_pulse), 64'd0);
        check("rise_valid_end", 64'(rec_valid),  64'd0);

        // two edges three cycles apart with the consumer stalled
        rst_n = 1'b0; tick();
        rst_n = 1'b1; din = 1'b1; rec_ready = 1'b0;
        tick(); tick();
        push_edge(1'b0);
        tick();
        check("ovf_fall",   64'(fall_pulse), 64'd1);
        check("ovf_held0",  64'(rec_data),   {31'd0, 1'b0, 32'd2});
        tick(); tick();
        din = 1'b1;           // dropped record: not pushed
        tick();
        check("ovf_rise",   64'(rise_pulse), 64'd1);
        check("ovf_flag",   64'(ovf),        64'd1);
        check("ovf_ecnt",   64'(edge_cnt),   64'd2);
        check("ovf_runl",   64'(run_len),    64'd3);
        check("ovf_valid",  64'(rec_valid),  64'd1);
        check("ovf_held",   64'(rec_data),   {31'd0, 1'b0, 32'd2});

        // disabled: din change ignored, handshake still drains
        en = 1'b0; din = 1'b0;
        tick();
        check("dis_fall",  64'(fall_pulse), 64'd0);
        check("dis_ecnt",  64'(edge_cnt),   64'd2);
        check("dis_valid", 64'(rec_valid),  64'd1);
        rec_ready = 1'b1;
        tick();
        check("dis_xfer",  64'(rec_valid),  64'd0);

        // build edge_cnt to 7, then clear coincident with an edge
        din = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_edge(~din);
            tick();
        end
        check("cnt7",      64'(edge_cnt), 64'd7);
        check("cnt7_ovf",  64'(ovf),      64'd1);
        clr_cnt = 1'b1;
        push_edge(~din);
        tick();
        clr_cnt = 1'b0;
        check("clr_ecnt",  64'(edge_cnt), 64'd1);
        check("clr_ovf",   64'(ovf),      64'd0);
        tick();
        check("clr_drain", 64'(rec_valid), 64'd0);

        // reset with a record pending: abandoned, then re-priming
        rec_ready = 1'b0;
        push_edge(~din);
        tick();
        check("pend_valid", 64'(rec_valid), 64'd1);
        void'(sb.pop_back());
        rst_n = 1'b0;
        tick();
        check("pend_rst_valid", 64'(rec_valid), 64'd0);
        check("pend_rst_data",  64'(rec_data),  64'd0);
        check("pend_rst_ecnt",  64'(edge_cnt),  64'd0);
        check("pend_rst_pulse", 64'({rise_pulse, fall_pulse}), 64'd0);
        rst_n = 1'b1; rec_ready = 1'b1; din = 1'b1;
        tick();
        check("reprime_rise", 64'(rise_pulse), 64'd0);
        check("reprime_ecnt", 64'(edge_cnt),   64'd0);
        push_edge(1'b0);
        tick();
        check("reprime_fall", 64'(fall_pulse), 64'd1);
        check("reprime_ecnt1", 64'(edge_cnt),  64'd1);
        tick();
        check("reprime_drain", 64'(rec_valid), 64'd0);
        en = 1'b0; rec_ready = 1'b0;

        // narrow instance: ts wrap and run_len / edge_cnt saturation
        tick();
        check("b_rst_runl", 64'(b_run_len), 64'd0);
        b_rst_n = 1'b1; b_en = 1'b1; b_rec_ready = 1'b1;
        repeat (20) tick();
        b_din = 1'b1;
        tick();
        check("b_rise",  64'(b_rise),     64'd1);
        check("b_wrap",  64'(b_rec_data), 64'h14);
        check("b_runl",  64'(b_run_len),  64'd15);
        check("b_ecnt",  64'(b_edge_cnt), 64'd1);
        for (int i = 0; i < 16; i++) begin
            b_din = ~b_din;
            tick();
        end
        check("b_ecnt_sat", 64'(b_edge_cnt), 64'd15);
        check("b_runl1",    64'(b_run_len),  64'd1);
        check("b_ovf",      64'(b_ovf),      64'd0);

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/edge_timestamp_monitor.md
EDGE_TIMESTAMP_MONITOR -- requirements
Module: edge_timestamp_monitor

Interface
REQ-001 Parameter TS_W, default 32, width of the free-running cycle timestamp.
REQ-002 Parameter CNT_W, default 16, width of the edge counter and the run-length fields.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 din  input  1  serial bit from the upstream D flip-flop stage (its q output); already synchronous to clk.
REQ-006 en  input  1  monitor enable; when low, all state holds except the record handshake.
REQ-007 clr_cnt  input  1  synchronous clear of edge_cnt and ovf.
REQ-008 rise_pulse  output  1  one-cycle pulse per detected 0->1 transition.
REQ-009 fall_pulse  output  1  one-cycle pulse per detected 1->0 transition.
REQ-010 edge_cnt  output  CNT_W  total edges detected, saturating.
REQ-011 run_len  output  CNT_W  length in cycles of the most recently completed stable run, saturating.
REQ-012 rec_valid  output  1  edge record available.
REQ-013 rec_ready  input  1  consumer accepts the record.
REQ-014 rec_data  output  TS_W+1  {polarity (1=rise), timestamp at detection}.
REQ-015 ovf  output  1  sticky flag: an edge record was dropped.

Function
REQ-016 The block SHALL register din into d1 on every enabled posedge; an edge SHALL be detected at posedge k when en=1, primed=1 and din != d1.
REQ-017 A primed flag SHALL be cleared by reset and set on the first enabled posedge; that first posedge SHALL load d1 without detecting an edge.
REQ-018 rise_pulse or fall_pulse SHALL be registered: high for exactly one cycle, during the cycle after detecting posedge k; never both high together.
REQ-019 ts SHALL increment by 1 on every enabled posedge, wrapping from 2^TS_W-1 to 0; rec_data timestamp SHALL be the ts value before that posedge's increment.
REQ-020 run_cnt SHALL increment on every enabled non-edge posedge, saturating at 2^CNT_W-1; on an edge, run_len SHALL be loaded with run_cnt and run_cnt set to 1.
REQ-021 edge_cnt SHALL increment per edge, saturating at 2^CNT_W-1.
REQ-022 clr_cnt=1 SHALL clear edge_cnt and ovf; if an edge occurs at the same posedge, edge_cnt SHALL become 1 and ovf SHALL follow REQ-025.
REQ-023 Record handshake: transfer occurs on a posedge with rec_valid=1 and rec_ready=1; rec_data SHALL be stable while rec_valid=1 and rec_ready=0.
REQ-024 On an edge with rec_valid=0, or rec_valid=1 and rec_ready=1 at the same posedge, rec_valid SHALL be 1 and rec_data loaded with the new record in the following cycle.
REQ-025 On an edge with rec_valid=1 and rec_ready=0, the held record SHALL be kept, the new record dropped and ovf set; pulses, edge_cnt and run_len SHALL still update.
REQ-026 With en=0, rec_valid SHALL still clear on transfer; no edges, ts or run_cnt changes.
REQ-027 Reset held mid-operation SHALL abandon any pending record without transfer.

Reset
REQ-028 With rst_n=0 at a posedge: rise_pulse=0, fall_pulse=0, edge_cnt=0, run_len=0, rec_valid=0, rec_data=0, ovf=0; internally ts=0, run_cnt=0, d1=0, primed=0.

Verification
REQ-029 Reset, en=1, din=1 from the first cycle -> no pulse, edge_cnt=0 (priming suppresses the false edge).
REQ-030 din 0 for 4 enabled cycles then 1, rec_ready=1 -> rise_pulse for one cycle, run_len=4, edge_cnt=1, rec_data={1,ts at detection} for one cycle.
REQ-031 Two edges 3 cycles apart, rec_ready=0 -> first record held, ovf=1, edge_cnt=2; raise rec_ready -> first record transfers, rec_valid drops.
REQ-032 clr_cnt asserted at the same posedge as an edge, edge_cnt previously 7 -> edge_cnt=1, ovf=0.
REQ-033 TS_W=4, 20 enabled cycles, then an edge -> timestamp wraps to detection count mod 16; CNT_W=4 with a 20-cycle run -> run_len=15.
REQ-034 rst_n low for one cycle while rec_valid=1 -> all outputs zero next cycle, no transfer, next din toggle not detected until re-primed.
